// File: rtl/vga_pkg.sv
// Shared constants, state type and small decode helper for the VGA timing generator.
package vga_pkg;

    // Default 640x480@60 Hz geometry (pixel clock 25.175 MHz)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_e;

    // True when lo <= v < hi_excl
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi_excl);
        return (v >= lo) && (v < hi_excl);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear to a preset vector.
module vga_delay_line #(
    parameter int                WIDTH   = 3,
    parameter int                DEPTH   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; clear loads the idle vector everywhere
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: lock synchronizer, IDLE/RUN control, x/y counters,
// pixel-request decode and delayed sync/enable outputs aligned to pixel data.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 2
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             pll_lock,
    output logic             req,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             de
);

    // Boundary values derived from the geometry parameters
    localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic             SYNC_ON      = 1'(SYNC_POL);
    localparam logic [2:0]       IDLE_VEC     = {1'b0, ~SYNC_ON, ~SYNC_ON};

    logic             lock_meta_q;
    logic             lock_s_q;
    vga_state_e       state_q;
    vga_state_e       state_d;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] x_d;
    logic [CNT_W-1:0] y_q;
    logic [CNT_W-1:0] y_d;
    logic             run_d;
    logic             req_q;
    logic             line_start_q;
    logic             frame_start_q;
    logic             hs_u;
    logic             vs_u;
    logic [2:0]       dl_in;
    logic [2:0]       dl_out;

    // Bring the asynchronous PLL lock flag into the pixel clock domain
    always_ff @(posedge clk) begin
        if (!RESET) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next state and next counter position; leaving RUN restarts at (0,0)
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                x_d = CNT_ZERO;
                y_d = CNT_ZERO;
                if (lock_s_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_IDLE;
                    x_d     = CNT_ZERO;
                    y_d     = CNT_ZERO;
                end else if (x_q == H_LAST) begin
                    state_d = ST_RUN;
                    x_d     = CNT_ZERO;
                    if (y_q == V_LAST) begin
                        y_d = CNT_ZERO;
                    end else begin
                        y_d = y_q + 10'd1;
                    end
                end else begin
                    state_d = ST_RUN;
                    x_d     = x_q + 10'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = CNT_ZERO;
                y_d     = CNT_ZERO;
            end
        endcase
        run_d = (state_d == ST_RUN);
    end

    // State, counters and request/pulse outputs, all registered
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            x_q           <= CNT_ZERO;
            y_q           <= CNT_ZERO;
            req_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            req_q         <= run_d && in_window(x_d, CNT_ZERO, H_VIS_END)
                                   && in_window(y_d, CNT_ZERO, V_VIS_END);
            line_start_q  <= run_d && (x_d == CNT_ZERO);
            frame_start_q <= run_d && (x_d == CNT_ZERO) && (y_d == CNT_ZERO);
        end
    end

    // Undelayed pin-level vector for the current counter position
    always_comb begin
        hs_u  = (state_q == ST_RUN) && in_window(x_q, H_SYNC_START, H_SYNC_END);
        vs_u  = (state_q == ST_RUN) && in_window(y_q, V_SYNC_START, V_SYNC_END);
        dl_in = {req_q, (hs_u ? SYNC_ON : ~SYNC_ON), (vs_u ? SYNC_ON : ~SYNC_ON)};
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (IDLE_VEC)
    ) u_delay (
        .clk   (clk),
        .clr_n (RESET),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    assign req         = req_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign de          = dl_out[2];
    assign hsync       = dl_out[1];
    assign vsync       = dl_out[0];

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a full-size 640x480 instance (delay 2,
// active-low syncs) and a tiny-geometry instance (delay 5, active-high syncs)
// share clock, reset and lock; both are compared every cycle against a model
// built from the running-cycle count since the last start.
module tb_vga_timing;

    localparam int MAXC = 100000;

    logic clk = 1'b0;
    logic RESET;
    logic pll_lock;

    logic       req_a, ls_a, fs_a, hs_a, vs_a, de_a;
    logic [9:0] x_a, y_a;
    logic       req_b, ls_b, fs_b, hs_b, vs_b, de_b;
    logic [9:0] x_b, y_b;

    bit rst_h  [MAXC];
    bit lock_h [MAXC];
    int cnt_h  [MAXC];
    int k;
    int tests;
    int fails;

    always #20 clk = ~clk;

    vga_timing u_a (
        .clk(clk), .RESET(RESET), .pll_lock(pll_lock),
        .req(req_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1), .PIPE_DELAY(5)
    ) u_b (
        .clk(clk), .RESET(RESET), .pll_lock(pll_lock),
        .req(req_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Pin-level {visible, hsync, vsync} for the position held after edge m
    function automatic logic [2:0] undel(int m, int ha, int hfp, int hsw, int hbp,
                                         int va, int vfp, int vsw, int vbp, logic pol);
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int pos, xx, yy;
        if (cnt_h[m] < 0) return {1'b0, ~pol, ~pol};
        pos = cnt_h[m] % (ht * vt);
        xx  = pos % ht;
        yy  = pos / ht;
        return {(xx < ha) && (yy < va),
                ((xx >= ha + hfp) && (xx < ha + hfp + hsw)) ? pol : ~pol,
                ((yy >= va + vfp) && (yy < va + vfp + vsw)) ? pol : ~pol};
    endfunction

    // Expected {req, line_start, frame_start, x, y, de, hsync, vsync} after edge kk
    function automatic logic [25:0] model(int kk, int ha, int hfp, int hsw, int hbp,
                                          int va, int vfp, int vsw, int vbp,
                                          logic pol, int pd);
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int pos, xx, yy;
        logic [2:0] dly;
        logic [2:0] top;
        bit clean = 1'b1;
        if (cnt_h[kk] < 0) begin
            xx  = 0;
            yy  = 0;
            top = 3'b000;
        end else begin
            pos = cnt_h[kk] % (ht * vt);
            xx  = pos % ht;
            yy  = pos / ht;
            top = {(xx < ha) && (yy < va), xx == 0, (xx == 0) && (yy == 0)};
        end
        for (int i = 0; i < pd; i++) begin
            if (!rst_h[kk - i]) clean = 1'b0;
        end
        dly = clean ? undel(kk - pd, ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pol)
                    : {1'b0, ~pol, ~pol};
        return {top, 10'(xx), 10'(yy), dly};
    endfunction

    // One clock: record the inputs seen at the edge, then check both instances
    task automatic tick();
        bit running;
        @(posedge clk);
        k++;
        if (k >= MAXC - 1) begin
            $display("FAIL cycle_budget k=%0d", k);
            $fatal(1, "cycle budget exceeded");
        end
        rst_h[k]  = RESET;
        lock_h[k] = pll_lock;
        running   = rst_h[k] && rst_h[k-1] && rst_h[k-2] && lock_h[k-2];
        cnt_h[k]  = running ? ((cnt_h[k-1] >= 0) ? cnt_h[k-1] + 1 : 0) : -1;
        @(negedge clk);
        chk("model_a", {req_a, ls_a, fs_a, x_a, y_a, de_a, hs_a, vs_a},
            model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2));
        chk("model_b", {req_b, ls_b, fs_b, x_b, y_b, de_b, hs_b, vs_b},
            model(k, 16, 2, 4, 3, 6, 2, 2, 3, 1'b1, 5));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int guard;
        tests    = 0;
        fails    = 0;
        RESET    = 1'b0;
        pll_lock = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            rst_h[i]  = 1'b0;
            lock_h[i] = 1'b0;
            cnt_h[i]  = -1;
        end
        k = 7;

        // Reset values
        tick();
        chk("reset_a", {req_a, ls_a, fs_a, x_a, y_a, de_a, hs_a, vs_a}, 32'h0000_0003);
        chk("reset_b", {req_b, ls_b, fs_b, x_b, y_b, de_b, hs_b, vs_b}, 32'h0000_0000);
        run(2);

        // Lock latency: RUN on the third edge, de PIPE_DELAY edges later
        RESET    = 1'b1;
        pll_lock = 1'b1;
        tick();
        chk("lock_e1_req", {31'd0, req_a}, 32'd0);
        tick();
        chk("lock_e2_req", {31'd0, req_a}, 32'd0);
        tick();
        chk("first_run", {req_a, fs_a, ls_a, x_a, y_a}, {3'b111, 20'd0});
        chk("first_de_lo", {31'd0, de_a}, 32'd0);
        tick();
        chk("de_a_e4", {31'd0, de_a}, 32'd0);
        tick();
        chk("de_a_e5", {31'd0, de_a}, 32'd1);
        run(2);
        chk("de_b_e7", {31'd0, de_b}, 32'd0);
        tick();
        chk("de_b_e8", {31'd0, de_b}, 32'd1);

        // Lock lost mid-line at (300, 2)
        guard = 0;
        while (cnt_h[k] != 2 * 800 + 300 && guard < 5000) begin
            tick();
            guard++;
        end
        chk("drop_pos", {x_a, y_a}, {10'd300, 10'd2});
        pll_lock = 1'b0;
        run(2);
        chk("drop_e2_x", {22'd0, x_a}, 32'd302);
        tick();
        chk("drop_idle", {req_a, ls_a, fs_a, x_a, y_a}, 32'd0);
        run(4);
        pll_lock = 1'b1;
        run(3);
        chk("relock", {req_a, fs_a, x_a, y_a}, {2'b11, 20'd0});

        // Several small-geometry frames
        run(1100);

        // Reset mid-line at x=700
        guard = 0;
        while ((cnt_h[k] < 0 || cnt_h[k] % 800 != 700) && guard < 1000) begin
            tick();
            guard++;
        end
        chk("rst_pos", {22'd0, x_a}, 32'd700);
        RESET = 1'b0;
        tick();
        chk("midrst_a", {req_a, ls_a, fs_a, x_a, y_a, de_a, hs_a, vs_a}, 32'h0000_0003);
        chk("midrst_b", {req_b, ls_b, fs_b, x_b, y_b, de_b, hs_b, vs_b}, 32'h0000_0000);
        RESET = 1'b1;
        run(2);
        chk("refill_e2", {31'd0, req_a}, 32'd0);
        tick();
        chk("refill_run", {req_a, fs_a, x_a, y_a}, {2'b11, 20'd0});

        // Randomized lock drops, resets and coincident reset/lock loss
        for (int it = 0; it < 24; it++) begin
            run($urandom_range(1, 2500));
            case ($urandom_range(0, 2))
                0: begin
                    pll_lock = 1'b0;
                    run($urandom_range(1, 8));
                    pll_lock = 1'b1;
                end
                1: begin
                    RESET = 1'b0;
                    run($urandom_range(1, 4));
                    RESET = 1'b1;
                end
                default: begin
                    RESET    = 1'b0;
                    pll_lock = 1'b0;
                    run($urandom_range(1, 4));
                    RESET    = 1'b1;
                    pll_lock = 1'b1;
                end
            endcase
        end
        run(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
